// File: rtl/i2c_target_responder.sv
// I2C target: oversampled SCL/SDA decode, 7-bit address match, command-byte
// capture on writes, 16-bit snapshot readout (low byte first) on reads.
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h5A,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] rd_data,
  output logic        rd_snap,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_CMD       = 3'd3;
  localparam logic [2:0] S_CMD_ACK   = 3'd4;
  localparam logic [2:0] S_TX        = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Synchronizers preset high so reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;

  logic [2:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  tx_shift;
  logic [15:0] snap;
  logic [1:0]  byte_idx;
  logic        rw;
  logic        ack_on;
  logic [7:0]  rx_byte;
  logic [7:0]  next_byte;

  assign rx_byte   = {shift[6:0], sda_s2};
  assign next_byte = (byte_idx == 2'd0) ? snap[15:8] : IDLE_BYTE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      tx_shift  <= 8'h00;
      snap      <= 16'h0000;
      byte_idx  <= 2'd0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      rd_snap   <= 1'b0;
      cmd       <= 8'h00;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rd_snap   <= 1'b0;
      if (stop_det) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else if (start_det) begin
        state   <= S_ADDR;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state <= S_ADDR_ACK;
                busy  <= 1'b1;
                rw    <= rx_byte[0];
              end else begin
                state <= S_WAIT_STOP;
              end
            end
          end
          // First fall drives ACK, second fall releases it (or starts TX).
          S_ADDR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              ack_on <= 1'b1;
              sda_oe <= 1'b1;
              if (rw) begin
                snap    <= rd_data;
                rd_snap <= 1'b1;
              end
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw) begin
                state    <= S_TX;
                byte_idx <= 2'd0;
                tx_shift <= snap[7:0];
                sda_oe   <= ~snap[7];
              end else begin
                state  <= S_CMD;
                sda_oe <= 1'b0;
              end
            end
          end
          S_CMD: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state     <= S_CMD_ACK;
              cmd       <= rx_byte;
              cmd_valid <= 1'b1;
            end
          end
          S_CMD_ACK: if (scl_fall) begin
            if (!ack_on) begin
              ack_on <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= S_CMD;
            end
          end
          S_TX: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= S_TX_ACK;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b0};
              sda_oe   <= ~tx_shift[6];
            end
          end
          // Master ACK is seen on the rise; the next byte starts on the fall.
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_s2) state <= S_WAIT_STOP;
              else        ack_on <= 1'b1;
            end else if (scl_fall && ack_on) begin
              ack_on   <= 1'b0;
              bit_cnt  <= 3'd0;
              tx_shift <= next_byte;
              sda_oe   <= ~next_byte[7];
              state    <= S_TX;
              if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
